// File: rtl/gridx_regfile_pkg.sv
`default_nettype none
// ============================================================================
// gridx_regfile_pkg: shared encodings for the warp register file  (rev 1.0)
// ============================================================================
package gridx_regfile_pkg;

  localparam logic [2:0] CORE_UPDATE = 3'b110;

  typedef enum logic [1:0] {
    MUX_ALU  = 2'b00,
    MUX_LSU  = 2'b01,
    MUX_IMM  = 2'b10,
    MUX_NONE = 2'b11
  } reg_mux_e;

  // Read-only registers sit at the top of the index space: NUM_REGS - offset.
  localparam int RO_BLOCK_IDX_OFS  = 3;
  localparam int RO_BLOCK_DIM_OFS  = 2;
  localparam int RO_THREAD_IDX_OFS = 1;
  localparam int RO_COUNT          = 3;

  function automatic logic is_writable(input int idx, input int num_regs);
    return (idx != 0) && (idx < num_regs - RO_COUNT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// regfile_scoreboard: pending-load tracking and operand hazard  (rev 1.0)
// ============================================================================
module regfile_scoreboard
  import gridx_regfile_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_i,
  input  logic [AW-1:0]       set_idx_i,
  input  logic                clr_i,
  input  logic [AW-1:0]       clr_idx_i,
  input  logic [AW-1:0]       rs_addr_i,
  input  logic [AW-1:0]       rt_addr_i,
  input  logic [AW-1:0]       rd_addr_i,
  output logic [NUM_REGS-1:0] pending_o,
  output logic                hazard_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;

  // Clear is applied first so a same-cycle issue to the same index wins.
  always_comb begin
    pending_d = pending_q;
    if (clr_i) pending_d[clr_idx_i] = 1'b0;
    if (set_i && is_writable(int'(set_idx_i), NUM_REGS)) pending_d[set_idx_i] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  assign pending_o = pending_q;
  assign hazard_o  = pending_q[rs_addr_i] | pending_q[rt_addr_i] | pending_q[rd_addr_i];

endmodule
`default_nettype wire

// File: rtl/warp_regfile_sb.sv
`default_nettype none
// ============================================================================
// warp_regfile_sb: per-thread register banks with load scoreboard  (rev 1.0)
// ============================================================================
module warp_regfile_sb
  import gridx_regfile_pkg::*;
#(
  parameter int THREADS   = 4,
  parameter int NUM_REGS  = 16,
  parameter int DATA_BITS = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [THREADS-1:0]           thread_mask,
  input  logic [7:0]                   block_id,
  input  logic [7:0]                   block_dim,
  input  logic [2:0]                   core_state,
  input  logic [$clog2(NUM_REGS)-1:0]  rs_addr,
  input  logic [$clog2(NUM_REGS)-1:0]  rt_addr,
  input  logic [$clog2(NUM_REGS)-1:0]  rd_addr,
  input  logic                         reg_write_enable,
  input  logic [1:0]                   reg_input_mux,
  input  logic [DATA_BITS-1:0]         immediate,
  input  logic [THREADS*DATA_BITS-1:0] alu_out,
  input  logic [THREADS*DATA_BITS-1:0] lsu_out,
  input  logic [THREADS-1:0]           force_we,
  input  logic [$clog2(NUM_REGS)-1:0]  force_dest,
  input  logic [THREADS*DATA_BITS-1:0] force_data,
  input  logic                         ld_issue,
  input  logic [$clog2(NUM_REGS)-1:0]  ld_issue_dest,
  input  logic                         ld_resp_valid,
  input  logic [$clog2(NUM_REGS)-1:0]  ld_resp_dest,
  input  logic [THREADS*DATA_BITS-1:0] ld_resp_data,
  output logic                         ld_resp_ready,
  output logic [THREADS*DATA_BITS-1:0] rs,
  output logic [THREADS*DATA_BITS-1:0] rt,
  output logic [THREADS*DATA_BITS-1:0] rd_val,
  output logic                         hazard,
  output logic [NUM_REGS-1:0]          pending
);

  localparam int AW             = $clog2(NUM_REGS);
  localparam int IDX_BLOCK_IDX  = NUM_REGS - RO_BLOCK_IDX_OFS;
  localparam int IDX_BLOCK_DIM  = NUM_REGS - RO_BLOCK_DIM_OFS;
  localparam int IDX_THREAD_IDX = NUM_REGS - RO_THREAD_IDX_OFS;
  localparam int LAST_RW        = NUM_REGS - RO_COUNT - 1;

  logic [7:0] block_idx_q, block_dim_q;
  logic       normal_qual;
  logic       resp_accept;

  // A qualified normal write owns the write port, so the load return must wait.
  assign normal_qual   = (core_state == CORE_UPDATE) && reg_write_enable &&
                         (reg_input_mux != MUX_NONE);
  assign ld_resp_ready = ~(|force_we) & ~normal_qual;
  assign resp_accept   = ld_resp_valid & ld_resp_ready;

  // Launch values are identical across threads, so one copy serves every bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      block_idx_q <= '0;
      block_dim_q <= 8'(THREADS);
    end else begin
      block_idx_q <= block_id;
      block_dim_q <= block_dim;
    end
  end

  for (genvar t = 0; t < THREADS; t++) begin : g_thread
    logic [DATA_BITS-1:0] bank_q [1:LAST_RW];
    logic [DATA_BITS-1:0] view   [NUM_REGS];
    logic                 wr_en;
    logic [AW-1:0]        wr_dest;
    logic [DATA_BITS-1:0] wr_data;
    logic [DATA_BITS-1:0] norm_data;

    always_comb begin
      case (reg_input_mux)
        MUX_ALU: norm_data = alu_out[t*DATA_BITS +: DATA_BITS];
        MUX_LSU: norm_data = lsu_out[t*DATA_BITS +: DATA_BITS];
        default: norm_data = immediate;
      endcase
    end

    always_comb begin
      wr_en   = 1'b0;
      wr_dest = '0;
      wr_data = '0;
      if (thread_mask[t]) begin
        if (force_we[t]) begin
          wr_en   = 1'b1;
          wr_dest = force_dest;
          wr_data = force_data[t*DATA_BITS +: DATA_BITS];
        end else if (resp_accept) begin
          wr_en   = 1'b1;
          wr_dest = ld_resp_dest;
          wr_data = ld_resp_data[t*DATA_BITS +: DATA_BITS];
        end else if (normal_qual) begin
          wr_en   = 1'b1;
          wr_dest = rd_addr;
          wr_data = norm_data;
        end
      end
    end

    // Only writable indices have storage; writes to r0 or read-only slots fall away.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 1; i <= LAST_RW; i++) bank_q[i] <= '0;
      end else if (wr_en) begin
        for (int i = 1; i <= LAST_RW; i++) begin
          if (wr_dest == AW'(i)) bank_q[i] <= wr_data;
        end
      end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_view
      if (i == 0) begin : g_zero
        assign view[i] = '0;
      end else if (i == IDX_BLOCK_IDX) begin : g_bidx
        assign view[i] = DATA_BITS'(block_idx_q);
      end else if (i == IDX_BLOCK_DIM) begin : g_bdim
        assign view[i] = DATA_BITS'(block_dim_q);
      end else if (i == IDX_THREAD_IDX) begin : g_tidx
        assign view[i] = DATA_BITS'(t);
      end else begin : g_rw
        assign view[i] = bank_q[i];
      end
    end

    assign rs[t*DATA_BITS +: DATA_BITS]     = view[rs_addr];
    assign rt[t*DATA_BITS +: DATA_BITS]     = view[rt_addr];
    assign rd_val[t*DATA_BITS +: DATA_BITS] = view[rd_addr];
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .set_i     (ld_issue),
    .set_idx_i (ld_issue_dest),
    .clr_i     (resp_accept),
    .clr_idx_i (ld_resp_dest),
    .rs_addr_i (rs_addr),
    .rt_addr_i (rt_addr),
    .rd_addr_i (rd_addr),
    .pending_o (pending),
    .hazard_o  (hazard)
  );

endmodule
`default_nettype wire

// File: tb/tb_warp_regfile_sb.sv
`default_nettype none
// tb_warp_regfile_sb: directed scenarios plus randomized traffic against an
// array-based model of the register file and its pending-load scoreboard.
module tb_warp_regfile_sb;
  localparam int T = 4;
  localparam int N = 16;
  localparam int D = 16;
  localparam int A = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [T-1:0]   thread_mask;
  logic [7:0]     block_id, block_dim;
  logic [2:0]     core_state;
  logic [A-1:0]   rs_addr, rt_addr, rd_addr;
  logic           reg_write_enable;
  logic [1:0]     reg_input_mux;
  logic [D-1:0]   immediate;
  logic [T*D-1:0] alu_out, lsu_out;
  logic [T-1:0]   force_we;
  logic [A-1:0]   force_dest;
  logic [T*D-1:0] force_data;
  logic           ld_issue;
  logic [A-1:0]   ld_issue_dest;
  logic           ld_resp_valid;
  logic [A-1:0]   ld_resp_dest;
  logic [T*D-1:0] ld_resp_data;
  logic           ld_resp_ready;
  logic [T*D-1:0] rs, rt, rd_val;
  logic           hazard;
  logic [N-1:0]   pending;

  int total = 0;
  int bad   = 0;

  logic [D-1:0] m_reg [T][N];
  logic [N-1:0] m_pend;
  logic         m_acc;

  warp_regfile_sb #(.THREADS(T), .NUM_REGS(N), .DATA_BITS(D)) dut (
    .clk(clk), .reset(reset), .thread_mask(thread_mask),
    .block_id(block_id), .block_dim(block_dim), .core_state(core_state),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .reg_write_enable(reg_write_enable), .reg_input_mux(reg_input_mux),
    .immediate(immediate), .alu_out(alu_out), .lsu_out(lsu_out),
    .force_we(force_we), .force_dest(force_dest), .force_data(force_data),
    .ld_issue(ld_issue), .ld_issue_dest(ld_issue_dest),
    .ld_resp_valid(ld_resp_valid), .ld_resp_dest(ld_resp_dest),
    .ld_resp_data(ld_resp_data), .ld_resp_ready(ld_resp_ready),
    .rs(rs), .rt(rt), .rd_val(rd_val), .hazard(hazard), .pending(pending)
  );

  // ---------------- reference model ----------------
  task automatic model_write(input int t, input logic [A-1:0] a, input logic [D-1:0] v);
    if (a != 0 && int'(a) < N - 3) m_reg[t][a] = v;
  endtask

  task automatic model_update();
    logic normal, rdy;
    logic [D-1:0] v;
    m_acc = 1'b0;
    if (reset) begin
      for (int t = 0; t < T; t++) begin
        for (int i = 0; i < N; i++) m_reg[t][i] = '0;
        m_reg[t][N-2] = D'(T);
        m_reg[t][N-1] = D'(t);
      end
      m_pend = '0;
      return;
    end
    normal = (core_state == 3'b110) && reg_write_enable && (reg_input_mux != 2'b11);
    rdy    = (force_we == '0) && !normal;
    m_acc  = ld_resp_valid && rdy;
    for (int t = 0; t < T; t++) begin
      if (thread_mask[t]) begin
        if (force_we[t]) model_write(t, force_dest, force_data[t*D +: D]);
        else if (m_acc)  model_write(t, ld_resp_dest, ld_resp_data[t*D +: D]);
        else if (normal) begin
          case (reg_input_mux)
            2'b00:   v = alu_out[t*D +: D];
            2'b01:   v = lsu_out[t*D +: D];
            default: v = immediate;
          endcase
          model_write(t, rd_addr, v);
        end
      end
    end
    for (int t = 0; t < T; t++) begin
      m_reg[t][N-3] = D'(block_id);
      m_reg[t][N-2] = D'(block_dim);
      m_reg[t][N-1] = D'(t);
    end
    if (m_acc) m_pend[ld_resp_dest] = 1'b0;
    if (ld_issue && ld_issue_dest != 0 && int'(ld_issue_dest) < N - 3) m_pend[ld_issue_dest] = 1'b1;
  endtask

  function automatic logic [T*D-1:0] exp_port(input logic [A-1:0] a);
    logic [T*D-1:0] r;
    for (int t = 0; t < T; t++) r[t*D +: D] = m_reg[t][a];
    return r;
  endfunction

  task automatic step();
    model_update();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_idle();
    reset = 1'b0; thread_mask = '1; core_state = 3'b000; reg_write_enable = 1'b0;
    reg_input_mux = 2'b11; immediate = '0; alu_out = '0; lsu_out = '0;
    force_we = '0; force_dest = '0; force_data = '0; ld_issue = 1'b0;
    ld_issue_dest = '0; ld_resp_valid = 1'b0; ld_resp_dest = '0; ld_resp_data = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive_idle();
    reset = 1'b1; block_id = 8'h21; block_dim = 8'd9;
    rs_addr = '0; rt_addr = '0; rd_addr = '0;
    step(); step();
    reset = 1'b0;
    rd_addr = 4'd15; #1;
    total++; if (rd_val[2*D +: D] !== 16'd2) begin bad++; $display("FAIL reset_tidx: got %h want 0002", rd_val[2*D +: D]); end
    total++; if (rd_val !== {16'd3, 16'd2, 16'd1, 16'd0}) begin bad++; $display("FAIL reset_tidx_all: got %h", rd_val); end
    rd_addr = 4'd14; #1;
    total++; if (rd_val[2*D +: D] !== 16'd4) begin bad++; $display("FAIL reset_bdim: got %h want 0004", rd_val[2*D +: D]); end
    rd_addr = 4'd13; #1;
    total++; if (rd_val !== '0) begin bad++; $display("FAIL reset_bidx: got %h want 0", rd_val); end
    rd_addr = 4'd0; #1;
    total++; if (rd_val[2*D +: D] !== 16'd0) begin bad++; $display("FAIL reset_r0: got %h want 0", rd_val[2*D +: D]); end
    total++; if (pending !== '0 || hazard !== 1'b0) begin bad++; $display("FAIL reset_sb: pending %h hazard %b want 0 0", pending, hazard); end
    total++; if (ld_resp_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ld_resp_ready); end
  endtask

  task automatic test_imm_write();
    drive_idle();
    core_state = 3'b110; reg_write_enable = 1'b1; reg_input_mux = 2'b10;
    immediate = 16'h00AB; rd_addr = 4'd5; thread_mask = 4'b0101; #1;
    total++; if (rd_val !== '0) begin bad++; $display("FAIL imm_no_bypass: got %h want 0", rd_val); end
    total++; if (ld_resp_ready !== 1'b0) begin bad++; $display("FAIL imm_ready: got %b want 0", ld_resp_ready); end
    step();
    drive_idle(); rd_addr = 4'd5; #1;
    total++; if (rd_val !== {16'h0, 16'h00AB, 16'h0, 16'h00AB}) begin bad++; $display("FAIL imm_write: got %h want 0000_00ab_0000_00ab", rd_val); end
  endtask

  task automatic test_load();
    drive_idle(); ld_issue = 1'b1; ld_issue_dest = 4'd7;
    step();
    drive_idle(); rs_addr = 4'd7; rt_addr = '0; rd_addr = '0; #1;
    total++; if (hazard !== 1'b1 || pending[7] !== 1'b1) begin bad++; $display("FAIL load_hazard: hazard %b pending %h want 1, bit7", hazard, pending); end
    step(); step();
    ld_resp_valid = 1'b1; ld_resp_dest = 4'd7; ld_resp_data = {4{16'h1111}}; #1;
    total++; if (ld_resp_ready !== 1'b1) begin bad++; $display("FAIL load_ready: got %b want 1", ld_resp_ready); end
    step();
    drive_idle(); rs_addr = 4'd7; #1;
    total++; if (pending[7] !== 1'b0 || hazard !== 1'b0) begin bad++; $display("FAIL load_clear: pending %h hazard %b want 0 0", pending, hazard); end
    total++; if (rs !== {4{16'h1111}}) begin bad++; $display("FAIL load_data: got %h want 1111 x4", rs); end
  endtask

  task automatic test_force_stall();
    drive_idle();
    ld_resp_valid = 1'b1; ld_resp_dest = 4'd8; ld_resp_data = {4{16'h2222}};
    force_we = 4'b0001; force_dest = 4'd9; force_data = {16'h0, 16'h0, 16'h0, 16'h3333}; #1;
    total++; if (ld_resp_ready !== 1'b0) begin bad++; $display("FAIL stall_ready: got %b want 0", ld_resp_ready); end
    step();
    force_we = '0; rs_addr = 4'd8; #1;
    total++; if (ld_resp_ready !== 1'b1) begin bad++; $display("FAIL stall_release: got %b want 1", ld_resp_ready); end
    total++; if (rs !== '0) begin bad++; $display("FAIL stall_held: got %h want 0", rs); end
    step();
    drive_idle(); rs_addr = 4'd8; rt_addr = 4'd9; #1;
    total++; if (rs !== {4{16'h2222}}) begin bad++; $display("FAIL stall_accept: got %h want 2222 x4", rs); end
    total++; if (rt !== {16'h0, 16'h0, 16'h0, 16'h3333}) begin bad++; $display("FAIL stall_force: got %h want 3333 in thread 0", rt); end
    total++; if (pending !== '0) begin bad++; $display("FAIL stall_pending: got %h want 0", pending); end
  endtask

  task automatic test_back_to_back();
    drive_idle(); ld_issue = 1'b1; ld_issue_dest = 4'd4;
    step();
    ld_resp_valid = 1'b1; ld_resp_dest = 4'd4; ld_resp_data = {4{16'h4444}}; #1;
    total++; if (ld_resp_ready !== 1'b1 || pending[4] !== 1'b1) begin bad++; $display("FAIL b2b_pre: ready %b pending %h want 1, bit4", ld_resp_ready, pending); end
    step();
    drive_idle(); rs_addr = 4'd4; #1;
    total++; if (pending[4] !== 1'b1) begin bad++; $display("FAIL b2b_issue_wins: pending %h want bit4 set", pending); end
    total++; if (rs !== {4{16'h4444}}) begin bad++; $display("FAIL b2b_data: got %h want 4444 x4", rs); end
    ld_resp_valid = 1'b1; ld_resp_dest = 4'd4; ld_resp_data = {4{16'h5555}};
    step();
    drive_idle(); #1;
    total++; if (pending[4] !== 1'b0 || hazard !== 1'b0) begin bad++; $display("FAIL b2b_clear: pending %h hazard %b want 0", pending, hazard); end
  endtask

  task automatic test_readonly();
    drive_idle();
    force_we = '1; force_dest = 4'd13; force_data = {4{16'hFFFF}};
    ld_issue = 1'b1; ld_issue_dest = 4'd13;
    step();
    drive_idle(); core_state = 3'b110; reg_write_enable = 1'b1; reg_input_mux = 2'b10;
    immediate = 16'hFFFF; rd_addr = 4'd13;
    step();
    drive_idle(); ld_resp_valid = 1'b1; ld_resp_dest = 4'd13; ld_resp_data = {4{16'hFFFF}};
    step();
    drive_idle(); rd_addr = 4'd13; rs_addr = 4'd14; rt_addr = 4'd15; #1;
    total++; if (rd_val !== {4{16'h0021}}) begin bad++; $display("FAIL ro_bidx: got %h want 0021 x4", rd_val); end
    total++; if (pending[13] !== 1'b0) begin bad++; $display("FAIL ro_pending: got %h want bit13 clear", pending); end
    total++; if (rs !== {4{16'h0009}}) begin bad++; $display("FAIL ro_bdim: got %h want 0009 x4", rs); end
    total++; if (rt !== {16'd3, 16'd2, 16'd1, 16'd0}) begin bad++; $display("FAIL ro_tidx: got %h", rt); end
    block_id = 8'hC5;
    step(); #1;
    total++; if (rd_val !== {4{16'h00C5}}) begin bad++; $display("FAIL ro_reload: got %h want 00c5 x4", rd_val); end
  endtask

  task automatic test_random();
    logic hold = 1'b0;
    logic normal, exp_rdy, exp_haz;
    for (int c = 0; c < 400; c++) begin
      reset            = ($urandom_range(0, 99) < 2);
      thread_mask      = 4'($urandom);
      core_state       = ($urandom_range(0, 1) == 1) ? 3'b110 : 3'($urandom);
      reg_write_enable = 1'($urandom);
      reg_input_mux    = 2'($urandom);
      immediate        = 16'($urandom);
      alu_out          = {$urandom, $urandom};
      lsu_out          = {$urandom, $urandom};
      force_we         = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      force_dest       = A'($urandom);
      force_data       = {$urandom, $urandom};
      ld_issue         = ($urandom_range(0, 2) == 0);
      ld_issue_dest    = A'($urandom);
      if (!hold) begin
        ld_resp_valid = ($urandom_range(0, 2) == 0);
        ld_resp_dest  = A'($urandom);
        ld_resp_data  = {$urandom, $urandom};
      end
      rs_addr = A'($urandom); rt_addr = A'($urandom); rd_addr = A'($urandom);
      block_id = 8'($urandom); block_dim = 8'($urandom);
      #1;
      normal  = (core_state == 3'b110) && reg_write_enable && (reg_input_mux != 2'b11);
      exp_rdy = (force_we == '0) && !normal;
      exp_haz = m_pend[rs_addr] | m_pend[rt_addr] | m_pend[rd_addr];
      total++; if (rs !== exp_port(rs_addr)) begin bad++; $display("FAIL rnd_rs c=%0d: got %h want %h", c, rs, exp_port(rs_addr)); end
      total++; if (rt !== exp_port(rt_addr)) begin bad++; $display("FAIL rnd_rt c=%0d: got %h want %h", c, rt, exp_port(rt_addr)); end
      total++; if (rd_val !== exp_port(rd_addr)) begin bad++; $display("FAIL rnd_rd c=%0d: got %h want %h", c, rd_val, exp_port(rd_addr)); end
      total++; if (pending !== m_pend) begin bad++; $display("FAIL rnd_pending c=%0d: got %h want %h", c, pending, m_pend); end
      total++; if (hazard !== exp_haz) begin bad++; $display("FAIL rnd_hazard c=%0d: got %b want %b", c, hazard, exp_haz); end
      total++; if (ld_resp_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, ld_resp_ready, exp_rdy); end
      step();
      hold = ld_resp_valid && !m_acc && !reset;
    end
  endtask

  initial begin
    drive_idle();
    block_id = '0; block_dim = '0;
    rs_addr = '0; rt_addr = '0; rd_addr = '0;
    m_pend = '0; m_acc = 1'b0;
    test_reset();
    test_imm_write();
    test_load();
    test_force_stall();
    test_back_to_back();
    test_readonly();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
